// File: rtl/sum_accumulator.sv
// Accumulates COUNT {carry, sum} beats from the adder into one widened total
// and hands it downstream over a valid/ready handshake; also reports per-cycle energy.
module sum_accumulator #(
  parameter  int WIDTH = 8,
  parameter  int COUNT = 4,
  localparam int OUT_W = WIDTH + 1 + $clog2(COUNT),
  localparam int CNT_W = $clog2(COUNT + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] sum_i,
  input  logic             c_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             clear_i,
  output logic [OUT_W-1:0] acc_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [63:0]      energy_o
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(COUNT - 1);
  localparam logic [63:0] E_BEAT = $realtobits(1.0e-12 * (0.012 * OUT_W + 0.035));
  localparam logic [63:0] E_HAND = $realtobits(1.0e-12 * 0.004);

  state_t           state_q;
  logic [OUT_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [OUT_W-1:0] op;

  // The operand is only consumed under valid_i, so X on idle inputs never reaches state.
  assign op = OUT_W'({c_i, sum_i});

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else if (clear_i) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i) begin
            acc_q   <= op;
            cnt_q   <= CNT_W'(1);
            state_q <= ACCUM;
          end
        end
        ACCUM: begin
          if (valid_i) begin
            acc_q <= acc_q + op;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BEAT) state_q <= DONE;
          end
        end
        DONE: begin
          if (ready_i) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          acc_q   <= '0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign ready_o = (state_q != DONE);
  assign valid_o = (state_q == DONE);
  assign acc_o   = valid_o ? acc_q : '0;
  assign cnt_o   = cnt_q;

  always_comb begin
    energy_o = 64'b0;
    if (valid_i && ready_o) begin
      energy_o = E_BEAT;
    end else if ((state_q == DONE) && ready_i && !clear_i) begin
      energy_o = E_HAND;
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// Self-checking bench for sum_accumulator (WIDTH=8, COUNT=4): table-driven frames,
// a scoreboard queue of expected totals, and hand-written corner sequences.
module tb_sum_accumulator;

  localparam int WIDTH = 8;
  localparam int COUNT = 4;
  localparam int OUT_W = 11;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] sum;
  logic             c;
  logic             valid_in;
  logic             ready_out;
  logic             clear;
  logic [OUT_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             valid_out;
  logic             ready_in;
  logic [63:0]      energy;

  sum_accumulator #(.WIDTH(WIDTH), .COUNT(COUNT)) dut (
    .clk_i(clk), .rst_ni(rst_n), .sum_i(sum), .c_i(c), .valid_i(valid_in),
    .ready_o(ready_out), .clear_i(clear), .acc_o(acc), .cnt_o(cnt),
    .valid_o(valid_out), .ready_i(ready_in), .energy_o(energy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][8:0] ops;
    logic [10:0]     exp_acc;
  } vec_t;

  vec_t        vecs [4];
  logic [10:0] sb_q [$];
  int          n_checks = 0;
  int          n_pass = 0;
  logic        prev_valid = 1'b0;
  logic [63:0] e_beat;
  logic [63:0] e_hand;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Advance one clock; sample 1 time unit after the edge and retire results on valid_o rise.
  task automatic tick();
    logic [10:0] e;
    @(posedge clk);
    #1;
    if (valid_out && !prev_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_result", 64'(acc), 64'hDEAD);
      end else begin
        e = sb_q.pop_front();
        check("scoreboard_acc", 64'(acc), 64'(e));
      end
    end
    prev_valid = valid_out;
  endtask

  task automatic drive_beat(input logic [8:0] op);
    valid_in = 1'b1;
    {c, sum} = op;
  endtask

  task automatic drive_idle();
    valid_in = 1'b0;
    c        = 1'bx;
    sum      = 'x;
  endtask

  // Four back-to-back beats, one DONE cycle with ready_i=1, back to IDLE.
  task automatic run_frame(input vec_t v);
    sb_q.push_back(v.exp_acc);
    ready_in = 1'b1;
    for (int i = 0; i < COUNT; i++) begin
      drive_beat(v.ops[i]);
      #1;
      check("beat_energy", energy, e_beat);
      tick();
      check("beat_cnt", 64'(cnt), 64'(i + 1));
    end
    drive_idle();
    check("done_valid", 64'(valid_out), 64'd1);
    check("done_ready", 64'(ready_out), 64'd0);
    #1;
    check("handoff_energy", energy, e_hand);
    tick();
    check("idle_valid", 64'(valid_out), 64'd0);
    check("idle_cnt", 64'(cnt), 64'd0);
    check("idle_acc", 64'(acc), 64'd0);
  endtask

  initial begin
    logic [2:0] gap_cnt [7];
    logic [8:0] gap_ops [7];
    logic       gap_val [7];
    vec_t       v;

    e_beat = $realtobits(1.0e-12 * (0.012 * 11 + 0.035));
    e_hand = $realtobits(1.0e-12 * 0.004);

    vecs[0] = '{ops: {9'd5, 9'd256, 9'd20, 9'd10}, exp_acc: 11'd291};
    vecs[1] = '{ops: {9'd511, 9'd511, 9'd511, 9'd511}, exp_acc: 11'd2044};
    vecs[2] = '{ops: {9'd400, 9'd300, 9'd200, 9'd100}, exp_acc: 11'd1000};
    vecs[3] = '{ops: {9'd1, 9'd1, 9'd1, 9'd1}, exp_acc: 11'd4};

    rst_n = 1'b0; clear = 1'b0; ready_in = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state_cnt", 64'(cnt), 64'd0);
    check("reset_valid", 64'(valid_out), 64'd0);
    check("reset_ready", 64'(ready_out), 64'd1);
    check("reset_acc", 64'(acc), 64'd0);
    check("reset_energy", energy, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    for (int i = 0; i < 4; i++) run_frame(vecs[i]);

    // Backpressure: result held for 5 cycles while extra beats are ignored.
    sb_q.push_back(11'd18);
    ready_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_beat(9'(3 + i));
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      drive_beat(9'd77);
      #1;
      check("hold_energy", energy, 64'd0);
      tick();
      check("hold_valid", 64'(valid_out), 64'd1);
      check("hold_acc", 64'(acc), 64'd18);
      check("hold_ready", 64'(ready_out), 64'd0);
      check("hold_cnt", 64'(cnt), 64'd4);
    end
    ready_in = 1'b1;
    #1;
    check("bp_handoff_energy", energy, e_hand);
    tick();
    drive_idle();
    check("bp_after_cnt", 64'(cnt), 64'd0);
    check("bp_after_valid", 64'(valid_out), 64'd0);
    run_frame(vecs[3]);

    // Gaps inside a frame: 2 beats, 3 idle cycles, 2 beats.
    gap_val = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    gap_ops = '{9'd7, 9'd8, 9'd0, 9'd0, 9'd0, 9'd9, 9'd10};
    gap_cnt = '{3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3, 3'd4};
    sb_q.push_back(11'd34);
    for (int i = 0; i < 7; i++) begin
      if (gap_val[i]) drive_beat(gap_ops[i]);
      else drive_idle();
      tick();
      check("gap_cnt", 64'(cnt), 64'(gap_cnt[i]));
    end
    drive_idle();
    tick();
    check("gap_return_idle", 64'(valid_out), 64'd0);

    // clear_i together with the third beat discards the partial frame.
    drive_beat(9'd50); tick();
    drive_beat(9'd60); tick();
    drive_beat(9'd70); clear = 1'b1; tick();
    clear = 1'b0; drive_idle();
    check("clear_cnt", 64'(cnt), 64'd0);
    check("clear_valid", 64'(valid_out), 64'd0);
    run_frame(vecs[3]);

    // clear_i while a result is held drops it without handoff.
    sb_q.push_back(11'd8);
    ready_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_beat(9'd2);
      tick();
    end
    drive_idle();
    clear = 1'b1;
    #1;
    check("clear_done_energy", energy, 64'd0);
    tick();
    clear = 1'b0;
    check("clear_done_valid", 64'(valid_out), 64'd0);
    check("clear_done_acc", 64'(acc), 64'd0);
    ready_in = 1'b1;

    // Asynchronous reset between edges in the middle of a frame.
    drive_beat(9'd30); tick();
    drive_beat(9'd40); tick();
    drive_idle();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_cnt", 64'(cnt), 64'd0);
    check("async_rst_valid", 64'(valid_out), 64'd0);
    check("async_rst_ready", 64'(ready_out), 64'd1);
    check("async_rst_energy", energy, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    run_frame(vecs[0]);

    v = '{ops: {9'd4, 9'd3, 9'd2, 9'd1}, exp_acc: 11'd10};
    run_frame(v);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
